// File: rtl/timer_counter_device_if.sv
// Data-bus port between the CPU memory stage and the timer peripheral.
// Master is the CPU side; slave is the timer.
interface timer_counter_device_if;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] WD;
    logic [31:0] RD;
    logic        IRQ;

    modport master (
        output Addr,
        output WE,
        output WD,
        input  RD,
        input  IRQ
    );

    modport slave (
        input  Addr,
        input  WE,
        input  WD,
        output RD,
        output IRQ
    );
endinterface

// File: rtl/timer_counter_device.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes.
// Optional TIMER_STATE_READ_EN: offset 0xC returns the FSM state for debug.
module timer_counter_device #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic                   clk,
    input  logic                   reset,
    timer_counter_device_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_q, irq_d;

    logic        hit;
    logic        wr_ctrl;
    logic        wr_preset;
    logic        en;
    logic [1:0]  mode;
    logic        im;
    logic        irq_set;
    logic [31:0] rd;
    logic        unused_addr;

    assign hit       = (bus.Addr[31:4] == BASE_ADDR[31:4]);
    assign wr_ctrl   = hit && bus.WE && (bus.Addr[3:2] == 2'd0);
    assign wr_preset = hit && bus.WE && (bus.Addr[3:2] == 2'd1);
    assign en        = ctrl_q[0];
    assign mode      = ctrl_q[2:1];
    assign im        = ctrl_q[3];
    assign unused_addr = ^bus.Addr[1:0];

    // Next-state logic: counter FSM, then CPU writes layered on top
    always_comb begin
        state_d  = state_q;
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        irq_d    = irq_q;
        irq_set  = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (count_q == 32'd0) begin
                    state_d = INT;
                    irq_d   = 1'b1;
                    irq_set = 1'b1;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            INT: begin
                if (mode == 2'b01) begin
                    state_d = LOAD;
                    irq_d   = 1'b0;
                end else begin
                    ctrl_d[0] = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A CPU write to CTRL overrides the hardware En-clear and acks the IRQ
        if (wr_ctrl) begin
            ctrl_d = bus.WD[3:0];
            if (!irq_set) begin
                irq_d = 1'b0;
            end
        end

        if (wr_preset) begin
            preset_d = bus.WD;
        end
    end

    // State and register update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            irq_q    <= irq_d;
        end
    end

    // Combinational read mux over the 16-byte window
    always_comb begin
        rd = 32'd0;
        if (hit) begin
            case (bus.Addr[3:2])
                2'd0: rd = {28'd0, ctrl_q};
                2'd1: rd = preset_q;
                2'd2: rd = count_q;
                2'd3: begin
`ifdef TIMER_STATE_READ_EN
                    rd = {30'd0, state_q};
`else
                    rd = 32'd0;
`endif
                end
                default: rd = 32'd0;
            endcase
        end
    end

    assign bus.RD  = rd;
    assign bus.IRQ = irq_q & im;

endmodule
